// File: rtl/ps_pkg.sv
// Shared types and constants for the pixel-stream kernel controller and its linebuffers.
package ps_pkg;

  localparam int unsigned NUM_BUFS  = 4;
  localparam int unsigned BUF_SEL_W = 2;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ROW_W     = 3 * PIX_W;

  typedef struct packed {
    logic [ROW_W-1:0] top;
    logic [ROW_W-1:0] mid;
    logic [ROW_W-1:0] bot;
  } window_t;

  typedef enum logic {
    KC_IDLE = 1'b0,
    KC_READ = 1'b1
  } kc_state_t;

  // Address width for a line of n pixels; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps_kernel_control_if.sv
// Pixel-in / window-out bus between the pixel source, the kernel controller and the conv core.
interface ps_kernel_control_if;

  logic                 i_valid;
  logic [7:0]           i_data;
  logic                 o_valid;
  ps_pkg::window_t      o_data;
  logic                 o_overflow;

  modport master (output i_valid, i_data, input  o_valid, o_data, o_overflow);
  modport slave  (input  i_valid, i_data, output o_valid, o_data, o_overflow);

endinterface

// File: rtl/ps_linebuffer.sv
// One line of pixel storage; a read returns {left, centre, right} with the edge pixel replicated.
module ps_linebuffer
  import ps_pkg::*;
#(
  parameter int unsigned LINE_LENGTH = 640
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_wr,
  input  logic [cnt_w(LINE_LENGTH)-1:0] i_waddr,
  input  logic [PIX_W-1:0]              i_wdata,
  input  logic                          i_rd,
  input  logic [cnt_w(LINE_LENGTH)-1:0] i_raddr,
  output logic [ROW_W-1:0]              o_rdata
);

  localparam int unsigned AW = cnt_w(LINE_LENGTH);

  logic [PIX_W-1:0] mem [LINE_LENGTH];
  logic [AW-1:0]    left_c;
  logic [AW-1:0]    right_c;
  logic [ROW_W-1:0] rdata_d;
  logic [ROW_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_wr) mem[i_waddr] <= i_wdata;
  end

  // Neighbour addresses clamp at both ends of the line to pad the edge windows.
  always_comb begin
    left_c  = (i_raddr == '0) ? i_raddr : i_raddr - AW'(1);
    right_c = (i_raddr == AW'(LINE_LENGTH - 1)) ? i_raddr : i_raddr + AW'(1);
    rdata_d = rdata_q;
    if (i_rd) rdata_d = {mem[left_c], mem[i_raddr], mem[right_c]};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/ps_kernel_control.sv
// Write/read sequencer over a ring of four linebuffers, producing one 3x3 window per read cycle.
module ps_kernel_control
  import ps_pkg::*;
#(
  parameter int unsigned LINE_LENGTH = 640
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  ps_kernel_control_if.slave  bus
);

  localparam int unsigned CNT_W  = cnt_w(LINE_LENGTH);
  localparam int unsigned FILL_W = $clog2(NUM_BUFS * LINE_LENGTH + 1);

  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [BUF_SEL_W-1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, sel_dly_q;
  logic [FILL_W-1:0]    fill_q, fill_d;
  kc_state_t            state_q, state_d;
  logic                 ovf_q, ovf_d;
  logic                 rd_dly_q, o_valid_q;
  window_t              o_data_q, o_data_d;
  logic                 accept_c, rd_c, rd_last_c;
  logic [NUM_BUFS-1:0]  buf_wr_c, buf_rd_c;
  logic [ROW_W-1:0]     rdata [NUM_BUFS];

  // Counters, fill accounting and read FSM.
  always_comb begin
    accept_c  = bus.i_valid && (fill_q < FILL_W'(NUM_BUFS * LINE_LENGTH));
    rd_c      = (state_q == KC_READ);
    rd_last_c = rd_c && (rd_cnt_q == CNT_W'(LINE_LENGTH - 1));

    wr_cnt_d = wr_cnt_q;
    wr_sel_d = wr_sel_q;
    rd_cnt_d = rd_cnt_q;
    rd_sel_d = rd_sel_q;
    state_d  = state_q;
    ovf_d    = ovf_q | (bus.i_valid & ~accept_c);
    fill_d   = fill_q + FILL_W'(accept_c) - (rd_last_c ? FILL_W'(LINE_LENGTH) : FILL_W'(0));

    if (accept_c) begin
      if (wr_cnt_q == CNT_W'(LINE_LENGTH - 1)) begin
        wr_cnt_d = '0;
        wr_sel_d = wr_sel_q + BUF_SEL_W'(1);
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      KC_IDLE: if (fill_q >= FILL_W'(3 * LINE_LENGTH)) state_d = KC_READ;
      KC_READ: begin
        if (rd_last_c) begin
          rd_cnt_d = '0;
          rd_sel_d = rd_sel_q + BUF_SEL_W'(1);
          state_d  = KC_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = KC_IDLE;
    endcase
  end

  // The three buffers at rd_sel..rd_sel+2 read together; the fourth is the write target.
  always_comb begin
    buf_wr_c = '0;
    buf_rd_c = '0;
    for (int unsigned g = 0; g < NUM_BUFS; g++) begin
      buf_wr_c[g] = accept_c && (wr_sel_q == BUF_SEL_W'(g));
      buf_rd_c[g] = rd_c && (BUF_SEL_W'(BUF_SEL_W'(g) - rd_sel_q) != BUF_SEL_W'(3));
    end
  end

  for (genvar g = 0; g < NUM_BUFS; g++) begin : g_lb
    ps_linebuffer #(.LINE_LENGTH(LINE_LENGTH)) u_lb (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_wr    (buf_wr_c[g]),
      .i_waddr (wr_cnt_q),
      .i_wdata (bus.i_data),
      .i_rd    (buf_rd_c[g]),
      .i_raddr (rd_cnt_q),
      .o_rdata (rdata[g])
    );
  end

  // Row mux uses the pointer captured with the read, so a rotation never splits a line.
  always_comb begin
    o_data_d = o_data_q;
    if (rd_dly_q) begin
      o_data_d.top = rdata[sel_dly_q];
      o_data_d.mid = rdata[BUF_SEL_W'(sel_dly_q + BUF_SEL_W'(1))];
      o_data_d.bot = rdata[BUF_SEL_W'(sel_dly_q + BUF_SEL_W'(2))];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_cnt_q  <= '0;
      wr_sel_q  <= '0;
      rd_cnt_q  <= '0;
      rd_sel_q  <= '0;
      sel_dly_q <= '0;
      fill_q    <= '0;
      state_q   <= KC_IDLE;
      ovf_q     <= 1'b0;
      rd_dly_q  <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_sel_q  <= wr_sel_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_sel_q  <= rd_sel_d;
      sel_dly_q <= rd_sel_q;
      fill_q    <= fill_d;
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      rd_dly_q  <= rd_c;
      o_valid_q <= rd_dly_q;
      o_data_q  <= o_data_d;
    end
  end

  assign bus.o_valid    = o_valid_q;
  assign bus.o_data     = o_data_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_ps_kernel_control.sv
// Self-checking bench for ps_kernel_control with LINE_LENGTH=8: scoreboard plus directed window table.
module tb_ps_kernel_control;
  import ps_pkg::*;

  localparam int L = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps_kernel_control_if bus();

  ps_kernel_control #(.LINE_LENGTH(L)) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int      line;
    int      col;
    window_t exp;
  } vec_t;

  int        n_checks = 0;
  int        n_fail   = 0;
  window_t   sb_q[$];
  logic [7:0] img [256];
  int        pix_cnt = 0;
  bit        sb_en   = 1'b1;
  int        run_len = 0;
  int        cap_line = 0;
  window_t   cap [8][8];
  vec_t      vecs [7];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] row_of(input int line, input int j);
    int cl = (j == 0) ? 0 : j - 1;
    int cr = (j == L - 1) ? j : j + 1;
    return {img[line*L + cl], img[line*L + j], img[line*L + cr]};
  endfunction

  function automatic window_t exp_win(input int k, input int j);
    window_t w;
    w.top = row_of(k, j);
    w.mid = row_of(k + 1, j);
    w.bot = row_of(k + 2, j);
    return w;
  endfunction

  // Drive one pixel for one cycle; a completed image line k+2 releases the windows of line k.
  task automatic send(input logic [7:0] v);
    bus.i_valid = 1'b1;
    bus.i_data  = v;
    if (pix_cnt < 256) img[pix_cnt] = v;
    pix_cnt++;
    if (sb_en && (pix_cnt % L == 0) && (pix_cnt >= 3*L))
      for (int j = 0; j < L; j++) sb_q.push_back(exp_win(pix_cnt/L - 3, j));
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    sb_q.delete();
    pix_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    idle(4);
    check(name, 72'(sb_q.size()), 72'(0));
  endtask

  // Output monitor: pops the scoreboard, captures windows, checks line length.
  always @(negedge clk) begin
    window_t e;
    if (!rst_n) begin
      run_len  = 0;
      cap_line = 0;
    end else if (bus.o_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_window: got %h expected no o_valid", bus.o_data);
      end else begin
        e = sb_q.pop_front();
        check("window", bus.o_data, e);
      end
      if (cap_line < 8 && run_len < 8) cap[cap_line][run_len] = bus.o_data;
      run_len++;
    end else if (run_len != 0) begin
      check("line_length", 72'(run_len), 72'(L));
      run_len = 0;
      cap_line++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 72'h000001_080809_101011};
    vecs[1] = '{0, 1, 72'h000102_08090A_101112};
    vecs[2] = '{0, 7, 72'h060707_0E0F0F_161717};
    vecs[3] = '{2, 3, 72'h121314_1A1B1C_222324};
    vecs[4] = '{3, 4, 72'h1B1C1D_232425_2B2C2D};
    vecs[5] = '{5, 0, 72'h282829_303031_383839};
    vecs[6] = '{5, 7, 72'h2E2F2F_363737_3E3F3F};

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_valid",    72'(bus.o_valid),    72'(0));
    check("reset_o_data",     bus.o_data,          72'(0));
    check("reset_o_overflow", 72'(bus.o_overflow), 72'(0));
    check("reset_fill",       72'(dut.fill_q),     72'(0));
    rst_n = 1'b1;

    // Threshold and start latency.
    for (int i = 0; i < 24; i++) send(8'(i));
    @(negedge clk); check("lat_c0", 72'(bus.o_valid), 72'(0));
    @(negedge clk); check("lat_c1", 72'(bus.o_valid), 72'(0));
    @(negedge clk); check("lat_c2", 72'(bus.o_valid), 72'(0));
    @(negedge clk); check("lat_c3", 72'(bus.o_valid), 72'(1));
    @(negedge clk); check("window1", bus.o_data, 72'h000102_08090A_101112);
    drain("thr_drain");

    // Back-to-back burst that fills the ring exactly.
    do_reset();
    for (int i = 0; i < 32; i++) send(8'(i));
    drain("cont_drain");
    check("cont_lines", 72'(cap_line), 72'(2));
    check("cont_ovf", 72'(bus.o_overflow), 72'(0));

    // Gapped 64-pixel stream.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      send(8'(i));
      idle(1);
    end
    drain("gap_drain");
    check("gap_lines", 72'(cap_line), 72'(6));
    check("gap_ovf", 72'(bus.o_overflow), 72'(0));
    for (int v = 0; v < 7; v++)
      check($sformatf("table_l%0d_w%0d", vecs[v].line, vecs[v].col),
            cap[vecs[v].line][vecs[v].col], vecs[v].exp);

    // Write on the last read cycle of line 0.
    do_reset();
    for (int i = 0; i < 24; i++) send(8'(i));
    idle(8);
    @(negedge clk);
    check("simul_fill_before", 72'(dut.fill_q), 72'(24));
    send(8'd24);
    check("simul_fill_after", 72'(dut.fill_q), 72'(17));
    for (int i = 25; i < 40; i++) send(8'(i));
    drain("simul_drain");
    check("simul_lines", 72'(cap_line), 72'(3));
    check("simul_ovf", 72'(bus.o_overflow), 72'(0));

    // Full ring with the reader held idle.
    do_reset();
    sb_en = 1'b0;
    force dut.state_q = KC_IDLE;
    for (int i = 0; i < 32; i++) send(8'(i));
    check("full_ovf_at_32", 72'(bus.o_overflow), 72'(0));
    for (int i = 32; i < 40; i++) send(8'(i));
    check("full_ovf", 72'(bus.o_overflow), 72'(1));
    check("full_fill", 72'(dut.fill_q), 72'(32));
    idle(5);
    check("full_ovf_sticky", 72'(bus.o_overflow), 72'(1));
    release dut.state_q;
    sb_en = 1'b1;

    // Reset in the middle of a read line, then a fresh stream.
    do_reset();
    for (int i = 0; i < 24; i++) send(8'(i));
    idle(5);
    check("mid_valid_before", 72'(bus.o_valid), 72'(1));
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 72'(bus.o_valid), 72'(0));
    do_reset();
    for (int i = 0; i < 24; i++) send(8'(8'h80 + i));
    drain("fresh_drain");
    check("fresh_window1", cap[0][1], 72'h808182_88898A_909192);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
